// File: rtl/chroma_key_ctrl.sv
// chroma_key_ctrl
// ----------------------------------------------------------------------------
// Configuration and calibration controller for the chroma-key mixer.
//
// The host writes the G_min / RG_max thresholds and the key enable into
// shadow registers. The shadows are copied to the live outputs only on a
// frame_start pulse, so a frame is always mixed with one consistent set.
//
// Auto-calibration averages 2^SAMPLE_LOG2 valid pixels of the green backdrop
// taken from a single frame. It derives new thresholds from the averages and
// writes them to the shadows. They go live at the next frame start, and
// calib_done pulses in the same cycle.
//
// Handshake: frame_start, calib_start and cfg_wr are single-cycle strobes
// sampled on the rising clock edge. rgb_data is used only in cycles where
// i_pixel_valid is high. There is no back-pressure, so every valid pixel
// seen while sampling is consumed.
//
// Ports:
//   clk, rst        pixel clock, asynchronous active-high reset
//   frame_start     one-cycle pulse at the start of each frame
//   i_pixel_valid   qualifies rgb_data
//   rgb_data        RGB565 camera pixel
//   cfg_wr          host write strobe
//   cfg_addr        0 = G_min, 1 = RG_max, 2 = ctrl (bit0 key_enable), 3 unused
//   cfg_wdata       host write data
//   calib_start     requests a calibration (ignored unless idle)
//   G_min, RG_max   live thresholds to the mixer
//   key_enable      live enable (mixer bypass when 0)
//   busy            high in any state other than IDLE
//   calib_done      one-cycle pulse when calibrated thresholds go live
//   dbg_state       current controller state, for observation only
// ----------------------------------------------------------------------------
module chroma_key_ctrl #(
    parameter int SAMPLE_LOG2 = 4,
    parameter int G_MARGIN    = 40,
    parameter int RB_MARGIN   = 40,
    parameter int G_MIN_RST   = 100,
    parameter int RG_MAX_RST  = 80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        i_pixel_valid,
    input  logic [15:0] rgb_data,
    input  logic        cfg_wr,
    input  logic [1:0]  cfg_addr,
    input  logic [7:0]  cfg_wdata,
    input  logic        calib_start,
    output logic [7:0]  G_min,
    output logic [7:0]  RG_max,
    output logic        key_enable,
    output logic        busy,
    output logic        calib_done,
    output logic [2:0]  dbg_state
);

    localparam int ACC_W = 8 + SAMPLE_LOG2;
    localparam int CNT_W = SAMPLE_LOG2 + 1;
    localparam logic [CNT_W-1:0] N_SAMPLES   = CNT_W'(1 << SAMPLE_LOG2);
    localparam logic [7:0]       G_MARGIN_B  = 8'(G_MARGIN);
    localparam logic [8:0]       RB_MARGIN_B = 9'(RB_MARGIN);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_FRAME = 3'd1,
        S_SAMPLE     = 3'd2,
        S_COMPUTE    = 3'd3,
        S_PENDING    = 3'd4
    } state_t;

    state_t           state_q;
    logic [7:0]       sh_g_min_q, sh_rg_max_q, g_min_q, rg_max_q;
    logic             sh_key_en_q, key_en_q, calib_done_q;
    logic [ACC_W-1:0] acc_g_q, acc_rb_q;
    logic [CNT_W-1:0] cnt_q;

    // Pixel decode and per-pixel contributions
    logic [7:0]       pix_r, pix_g, pix_b, pix_rb;
    logic [ACC_W-1:0] acc_g_d, acc_rb_d;
    logic [CNT_W-1:0] cnt_d;
    logic [7:0]       avg_g, avg_rb, g_min_d, rg_max_d;
    logic [8:0]       rb_sum;

    always_comb begin
        pix_r  = {rgb_data[15:11], 3'b000};
        pix_g  = {rgb_data[10:5],  2'b00};
        pix_b  = {rgb_data[4:0],   3'b000};
        pix_rb = (pix_r > pix_b) ? pix_r : pix_b;

        // A frame_start restarts the window from zero, and the pixel in that
        // same cycle (if valid) becomes sample 0.
        acc_g_d  = frame_start ? '0 : acc_g_q;
        acc_rb_d = frame_start ? '0 : acc_rb_q;
        cnt_d    = frame_start ? '0 : cnt_q;
        if (i_pixel_valid) begin
            acc_g_d  = acc_g_d  + ACC_W'(pix_g);
            acc_rb_d = acc_rb_d + ACC_W'(pix_rb);
            cnt_d    = cnt_d + 1'b1;
        end

        avg_g    = acc_g_q[ACC_W-1:SAMPLE_LOG2];
        avg_rb   = acc_rb_q[ACC_W-1:SAMPLE_LOG2];
        g_min_d  = (avg_g > G_MARGIN_B) ? (avg_g - G_MARGIN_B) : 8'd0;
        rb_sum   = {1'b0, avg_rb} + RB_MARGIN_B;
        rg_max_d = rb_sum[8] ? 8'hFF : rb_sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sh_g_min_q   <= 8'(G_MIN_RST);
            sh_rg_max_q  <= 8'(RG_MAX_RST);
            sh_key_en_q  <= 1'b0;
            g_min_q      <= 8'(G_MIN_RST);
            rg_max_q     <= 8'(RG_MAX_RST);
            key_en_q     <= 1'b0;
            calib_done_q <= 1'b0;
            acc_g_q      <= '0;
            acc_rb_q     <= '0;
            cnt_q        <= '0;
        end else begin
            calib_done_q <= 1'b0;

            // Live outputs only ever change here, on a frame boundary.
            if (frame_start) begin
                g_min_q  <= sh_g_min_q;
                rg_max_q <= sh_rg_max_q;
                key_en_q <= sh_key_en_q;
            end

            // Host writes are blocked only in COMPUTE, where the calibrated
            // values are being written to the same shadows.
            if (cfg_wr && state_q != S_COMPUTE) begin
                case (cfg_addr)
                    2'd0:    sh_g_min_q  <= cfg_wdata;
                    2'd1:    sh_rg_max_q <= cfg_wdata;
                    2'd2:    sh_key_en_q <= cfg_wdata[0];
                    default: ;
                endcase
            end

            case (state_q)
                S_IDLE: begin
                    if (calib_start) state_q <= S_WAIT_FRAME;
                end
                S_WAIT_FRAME: begin
                    if (frame_start) begin
                        acc_g_q  <= acc_g_d;
                        acc_rb_q <= acc_rb_d;
                        cnt_q    <= cnt_d;
                        state_q  <= (cnt_d == N_SAMPLES) ? S_COMPUTE : S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (frame_start || i_pixel_valid) begin
                        acc_g_q  <= acc_g_d;
                        acc_rb_q <= acc_rb_d;
                        cnt_q    <= cnt_d;
                        if (cnt_d == N_SAMPLES) state_q <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    sh_g_min_q  <= g_min_d;
                    sh_rg_max_q <= rg_max_d;
                    sh_key_en_q <= 1'b1;
                    state_q     <= S_PENDING;
                end
                S_PENDING: begin
                    if (frame_start) begin
                        calib_done_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign G_min      = g_min_q;
    assign RG_max     = rg_max_q;
    assign key_enable = key_en_q;
    assign calib_done = calib_done_q;
    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_chroma_key_ctrl.sv
// Testbench for chroma_key_ctrl: directed scenarios plus random traffic,
// checked every cycle against a behavioural model kept in this file.
module tb_chroma_key_ctrl;

  localparam int NS = 16;

  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_SAMP = 2;
  localparam int P_COMP = 3;
  localparam int P_PEND = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        d_fs, d_v, d_wr, d_cs;
  logic [15:0] d_px;
  logic [1:0]  d_addr;
  logic [7:0]  d_wdata;
  logic [7:0]  G_min, RG_max;
  logic        key_enable, busy, calib_done;
  logic [2:0]  dbg_state;

  chroma_key_ctrl dut (
    .clk(clk), .rst(rst), .frame_start(d_fs), .i_pixel_valid(d_v),
    .rgb_data(d_px), .cfg_wr(d_wr), .cfg_addr(d_addr), .cfg_wdata(d_wdata),
    .calib_start(d_cs), .G_min(G_min), .RG_max(RG_max),
    .key_enable(key_enable), .busy(busy), .calib_done(calib_done),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_phase;
  int m_sh_g, m_sh_rb, m_sh_en;
  int m_g, m_rb, m_en, m_done;
  int samp_g[$];
  int samp_rb[$];

  task automatic m_reset();
    m_phase = P_IDLE;
    m_sh_g = 100; m_sh_rb = 80; m_sh_en = 0;
    m_g = 100; m_rb = 80; m_en = 0; m_done = 0;
    samp_g.delete(); samp_rb.delete();
  endtask

  task automatic m_take_pixel();
    int r, g, b;
    r = (int'(d_px) >> 11) * 8;
    g = ((int'(d_px) >> 5) % 64) * 4;
    b = (int'(d_px) % 32) * 8;
    samp_g.push_back(g);
    samp_rb.push_back(r > b ? r : b);
  endtask

  task automatic m_step();
    int nxt, sg, srb, ag, arb;
    nxt = m_phase;
    m_done = 0;
    if (d_fs) begin
      m_g = m_sh_g; m_rb = m_sh_rb; m_en = m_sh_en;
    end
    if (d_wr && m_phase != P_COMP) begin
      if (d_addr == 0) m_sh_g = d_wdata;
      else if (d_addr == 1) m_sh_rb = d_wdata;
      else if (d_addr == 2) m_sh_en = d_wdata[0];
    end
    case (m_phase)
      P_IDLE: if (d_cs) nxt = P_WAIT;
      P_WAIT, P_SAMP: begin
        if (d_fs) begin
          samp_g.delete(); samp_rb.delete();
        end
        if (d_fs || m_phase == P_SAMP) begin
          if (d_v) m_take_pixel();
          nxt = (samp_g.size() == NS) ? P_COMP : P_SAMP;
        end
      end
      P_COMP: begin
        sg = 0; srb = 0;
        foreach (samp_g[i]) begin
          sg += samp_g[i];
          srb += samp_rb[i];
        end
        ag = sg / NS;
        arb = srb / NS;
        m_sh_g = (ag - 40 < 0) ? 0 : ag - 40;
        m_sh_rb = (arb + 40 > 255) ? 255 : arb + 40;
        m_sh_en = 1;
        nxt = P_PEND;
      end
      P_PEND: if (d_fs) begin
        m_done = 1;
        nxt = P_IDLE;
      end
      default: nxt = P_IDLE;
    endcase
    m_phase = nxt;
  endtask

  task automatic check_all();
    check_eq("g_min", G_min, m_g);
    check_eq("rg_max", RG_max, m_rb);
    check_eq("key_enable", key_enable, m_en);
    check_eq("busy", busy, m_phase != P_IDLE);
    check_eq("calib_done", calib_done, m_done);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic fs, input logic v, input logic [15:0] px,
                     input logic wr, input logic [1:0] a, input logic [7:0] wd,
                     input logic cs);
    @(negedge clk);
    d_fs = fs; d_v = v; d_px = px; d_wr = wr; d_addr = a; d_wdata = wd; d_cs = cs;
    @(posedge clk);
    m_step();
    #1;
    check_all();
    if (calib_done) n_done++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, 0, 2'd0, 8'h0, 0);
  endtask

  task automatic fs_pulse(input logic v, input logic [15:0] px);
    cyc(1, v, px, 0, 2'd0, 8'h0, 0);
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [7:0] wd);
    cyc(0, 0, 16'h0, 1, a, wd, 0);
  endtask

  task automatic pixels(input int n, input logic [15:0] px);
    for (int i = 0; i < n; i++) cyc(0, 1, px, 0, 2'd0, 8'h0, 0);
  endtask

  task automatic start_calib();
    cyc(0, 0, 16'h0, 0, 2'd0, 8'h0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    d_fs = 0; d_v = 0; d_px = 0; d_wr = 0; d_addr = 0; d_wdata = 0; d_cs = 0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Frame-aligned commit, including an ignored write to address 3
    idle(3);
    host_wr(2'd0, 8'h90);
    host_wr(2'd2, 8'h01);
    host_wr(2'd3, 8'h55);
    idle(4);
    fs_pulse(0, 16'h0);
    check_eq("commit_g_min", G_min, 32'h90);
    check_eq("commit_key_en", key_enable, 1);
    idle(3);

    // Pure-green calibration, with a host write and a second calib_start
    // arriving while sampling
    n_done = 0;
    start_calib();
    idle(2);
    fs_pulse(0, 16'h0);
    pixels(3, 16'h07E0);
    start_calib();
    pixels(2, 16'h07E0);
    host_wr(2'd0, 8'h11);
    pixels(11, 16'h07E0);
    idle(4);
    fs_pulse(0, 16'h0);
    idle(3);
    check_eq("green_g_min", G_min, 212);
    check_eq("green_rg_max", RG_max, 40);
    check_eq("green_key_en", key_enable, 1);
    check_eq("green_done_cnt", n_done, 1);
    check_eq("green_busy", busy, 0);

    // Saturation on both thresholds
    start_calib();
    fs_pulse(1, 16'hF800);
    pixels(15, 16'hF800);
    idle(2);
    fs_pulse(0, 16'h0);
    idle(2);
    check_eq("sat_g_min", G_min, 0);
    check_eq("sat_rg_max", RG_max, 255);

    // Short frame of red pixels discarded; host write lands on the
    // cycle right after the window fills
    n_done = 0;
    start_calib();
    fs_pulse(0, 16'h0);
    pixels(10, 16'hF800);
    fs_pulse(1, 16'h07E0);
    pixels(15, 16'h07E0);
    host_wr(2'd1, 8'h05);
    idle(2);
    fs_pulse(0, 16'h0);
    idle(2);
    check_eq("short_g_min", G_min, 212);
    check_eq("short_rg_max", RG_max, 40);
    check_eq("short_done_cnt", n_done, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic fs, v, wr, cs;
      logic [15:0] px;
      fs = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 3) != 0);
      wr = ($urandom_range(0, 19) == 0);
      cs = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0: px = 16'h07E0;
        1: px = 16'hF800;
        default: px = 16'($urandom_range(0, 65535));
      endcase
      cyc(fs, v, px, wr, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), cs);
    end

    // Asynchronous reset in the middle of a calibration
    host_wr(2'd2, 8'h01);
    fs_pulse(0, 16'h0);
    start_calib();
    fs_pulse(1, 16'h07E0);
    pixels(4, 16'h07E0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    check_eq("arst_g_min", G_min, 100);
    check_eq("arst_rg_max", RG_max, 80);
    check_eq("arst_key_en", key_enable, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", calib_done, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
